// File: rtl/switch_arbiter_if.sv
// Handshake bundle between the switch ports (master side) and the central output arbiter (slave side).
interface switch_arbiter_if;
    logic [3:0] req;
    logic [3:0] pkt_dst0;
    logic [3:0] pkt_dst1;
    logic [3:0] pkt_dst2;
    logic [3:0] pkt_dst3;
    logic [3:0] grant;
    logic [1:0] mux_select0;
    logic [1:0] mux_select1;
    logic [1:0] mux_select2;
    logic [1:0] mux_select3;
    logic [3:0] out_en;
    logic [3:0] starved;

    modport master (
        output req, pkt_dst0, pkt_dst1, pkt_dst2, pkt_dst3,
        input  grant, mux_select0, mux_select1, mux_select2, mux_select3, out_en, starved
    );

    modport slave (
        input  req, pkt_dst0, pkt_dst1, pkt_dst2, pkt_dst3,
        output grant, mux_select0, mux_select1, mux_select2, mux_select3, out_en, starved
    );
endinterface

// File: rtl/switch_arbiter.sv
// Central output arbiter for the 4-port switch: round-robin, atomic multicast grants,
// starvation aging with output reservation; grant pulse followed by one transfer cycle.
module switch_arbiter #(
    parameter int NPORTS   = 4,
    parameter int MAX_WAIT = 15,
    parameter int CNT_W    = 4
) (
    input logic             clk,
    input logic             rst_n,
    switch_arbiter_if.slave bus
);

    localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(MAX_WAIT);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_GNT,
        ST_XFER
    } src_state_e;

    src_state_e        state_q [NPORTS];
    src_state_e        state_d [NPORTS];
    logic [NPORTS-1:0] mask_q  [NPORTS];
    logic [CNT_W-1:0]  cnt_q   [NPORTS];
    logic [1:0]        rr_q;

    logic [NPORTS-1:0] dst     [NPORTS];
    logic [NPORTS-1:0] busy;
    logic [NPORTS-1:0] taken;
    logic [NPORTS-1:0] win;
    logic [NPORTS-1:0] eligible;
    logic [NPORTS-1:0] starved_v;
    logic [NPORTS-1:0] grant_v;
    logic [NPORTS-1:0] out_en_v;
    logic [1:0]        mux_v   [NPORTS];
    logic [1:0]        scan_idx;
    logic [1:0]        first_idx;
    logic              first_found;

    assign dst[0] = bus.pkt_dst0;
    assign dst[1] = bus.pkt_dst1;
    assign dst[2] = bus.pkt_dst2;
    assign dst[3] = bus.pkt_dst3;

    // Arbitration: starved sources scan first, then the rest; a losing starved
    // source still claims its outputs so nobody scanned after it can take them.
    always_comb begin
        // NOTE: every variable gets a default before any conditional write, so no latch is inferred.
        busy        = '0;
        eligible    = '0;
        starved_v   = '0;
        win         = '0;
        first_found = 1'b0;
        first_idx   = '0;
        scan_idx    = '0;
        for (int i = 0; i < NPORTS; i++) begin
            if (state_q[i] == ST_GNT) busy |= mask_q[i];
            eligible[i]  = (state_q[i] == ST_IDLE) && bus.req[i] && (dst[i] != '0);
            starved_v[i] = (cnt_q[i] == MAX_CNT);
        end
        taken = busy;
        for (int p = 0; p < 2; p++) begin
            for (int k = 0; k < NPORTS; k++) begin
                scan_idx = rr_q + 2'(k);
                if (eligible[scan_idx] && (starved_v[scan_idx] == (p == 0))) begin
                    if ((dst[scan_idx] & taken) == '0) begin
                        win[scan_idx] = 1'b1;
                        taken        |= dst[scan_idx];
                        if (!first_found) begin
                            first_found = 1'b1;
                            first_idx   = scan_idx;
                        end
                    end else if (starved_v[scan_idx]) begin
                        taken |= dst[scan_idx];
                    end
                end
            end
        end
    end

    always_comb begin
        for (int i = 0; i < NPORTS; i++) begin
            state_d[i] = ST_IDLE;
            case (state_q[i])
                ST_IDLE: state_d[i] = win[i] ? ST_GNT : ST_IDLE;
                ST_GNT:  state_d[i] = ST_XFER;
                ST_XFER: state_d[i] = ST_IDLE;
                default: state_d[i] = ST_IDLE;
            endcase
        end
    end

    always_comb begin
        grant_v  = '0;
        out_en_v = '0;
        for (int o = 0; o < NPORTS; o++) mux_v[o] = '0;
        for (int i = 0; i < NPORTS; i++) begin
            grant_v[i] = (state_q[i] == ST_GNT);
            if (state_q[i] == ST_XFER) begin
                for (int o = 0; o < NPORTS; o++) begin
                    if (mask_q[i][o]) begin
                        out_en_v[o] = 1'b1;
                        mux_v[o]    = 2'(i);
                    end
                end
            end
        end
    end

    // NOTE: state is updated with non-blocking assignments so every process sees the pre-edge values.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rr_q <= '0;
            for (int i = 0; i < NPORTS; i++) begin
                state_q[i] <= ST_IDLE;
                mask_q[i]  <= '0;
                cnt_q[i]   <= '0;
            end
        end else begin
            if (first_found) rr_q <= first_idx + 2'd1;
            for (int i = 0; i < NPORTS; i++) begin
                state_q[i] <= state_d[i];
                if (win[i]) mask_q[i] <= dst[i];
                if (!bus.req[i] || win[i]) begin
                    cnt_q[i] <= '0;
                end else if (eligible[i] && (cnt_q[i] != MAX_CNT)) begin
                    cnt_q[i] <= cnt_q[i] + 1'b1;
                end
            end
        end
    end

    assign bus.grant       = grant_v;
    assign bus.out_en      = out_en_v;
    assign bus.starved     = starved_v;
    assign bus.mux_select0 = mux_v[0];
    assign bus.mux_select1 = mux_v[1];
    assign bus.mux_select2 = mux_v[2];
    assign bus.mux_select3 = mux_v[3];

endmodule
